// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: step/load controls in, count and flags out.
// Parameter WIDTH must match the counter instance it connects to.
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             sat;

  modport master (
    output en, dir, mode, load, load_val,
    input  cnt, tc, sat
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output cnt, tc, sat
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MODULO up/down counter with wrap, saturate and ping-pong modes,
// parallel load, and registered terminal-count / saturation flags.
module mod_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input logic          clk,
  input logic          rst,
  mod_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_SAT  = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  generate
    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
      $error("mod_counter: MODULO must lie in 2..2**WIDTH");
    end
  endgenerate

  mode_t            mode_in;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             pp_dn, pp_dn_d;

  assign mode_in = mode_t'(bus.mode);

  // Load beats stepping; only saturate mode may hold sat, so any other mode drops it.
  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    sat_d   = sat_q;
    pp_dn_d = pp_dn;
    if (bus.load) begin
      cnt_d = (bus.load_val > MAXV) ? MAXV : bus.load_val;
      sat_d = 1'b0;
    end else if (bus.en && mode_in != MODE_HOLD) begin
      case (mode_in)
        MODE_WRAP: begin
          if (!bus.dir) begin
            if (cnt_q == MAXV) begin
              cnt_d = ZERO;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else begin
            if (cnt_q == ZERO) begin
              cnt_d = MAXV;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        MODE_SAT: begin
          if (!bus.dir) begin
            if (cnt_q == MAXV) begin
              sat_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
              tc_d  = (cnt_d == MAXV);
              sat_d = 1'b0;
            end
          end else begin
            if (cnt_q == ZERO) begin
              sat_d = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
              tc_d  = (cnt_d == ZERO);
              sat_d = 1'b0;
            end
          end
        end
        // Direction reverses on the step leaving an extreme, never by repeating it.
        MODE_PP: begin
          if (!pp_dn) begin
            if (cnt_q == MAXV) begin
              cnt_d   = cnt_q - ONE;
              pp_dn_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else begin
            if (cnt_q == ZERO) begin
              cnt_d   = ONE;
              pp_dn_d = 1'b0;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
          tc_d = (cnt_d == ZERO) || (cnt_d == MAXV);
        end
        default: ;
      endcase
    end
    if (mode_in != MODE_SAT) sat_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      sat_q <= 1'b0;
      pp_dn <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      sat_q <= sat_d;
      pp_dn <= pp_dn_d;
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.sat = sat_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three instances (16/W4, 10/W4, 4/W3) share
// stimulus; each vector targets one instance and queues its expected outputs.
module tb_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) bus16 ();
  mod_counter_if #(.WIDTH(4)) bus10 ();
  mod_counter_if #(.WIDTH(3)) bus4 ();

  mod_counter #(.WIDTH(4), .MODULO(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  mod_counter #(.WIDTH(4), .MODULO(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
  mod_counter #(.WIDTH(3), .MODULO(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    int         id;
    logic [3:0] cnt;
    logic       tc;
    logic       sat;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one vector at the falling edge, queue the expectation after the
  // rising edge, and return at the next falling edge.
  task automatic applyStimulus(input int id, input logic r, input logic e, input logic d,
                               input logic [1:0] m, input logic ld, input logic [3:0] lv,
                               input logic [3:0] ecnt, input logic etc, input logic esat,
                               input string name);
    exp_t x;
    rst = r;
    bus16.en = e;  bus16.dir = d;  bus16.mode = m;  bus16.load = ld;  bus16.load_val = lv;
    bus10.en = e;  bus10.dir = d;  bus10.mode = m;  bus10.load = ld;  bus10.load_val = lv;
    bus4.en  = e;  bus4.dir  = d;  bus4.mode  = m;  bus4.load  = ld;  bus4.load_val  = lv[2:0];
    @(posedge clk);
    #1;
    x.id = id; x.cnt = ecnt; x.tc = etc; x.sat = esat; x.name = name;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t x);
    logic [3:0] acnt;
    logic       atc, asat;
    case (x.id)
      0:       begin acnt = bus16.cnt;        atc = bus16.tc; asat = bus16.sat; end
      1:       begin acnt = bus10.cnt;        atc = bus10.tc; asat = bus10.sat; end
      default: begin acnt = {1'b0, bus4.cnt}; atc = bus4.tc;  asat = bus4.sat;  end
    endcase
    total++;
    if (acnt !== x.cnt) begin
      bad++;
      $display("[TB] FAIL %s cnt: got %0d want %0d", x.name, acnt, x.cnt);
    end
    total++;
    if (atc !== x.tc) begin
      bad++;
      $display("[TB] FAIL %s tc: got %b want %b (cnt=%0d)", x.name, atc, x.tc, acnt);
    end
    total++;
    if (asat !== x.sat) begin
      bad++;
      $display("[TB] FAIL %s sat: got %b want %b (cnt=%0d)", x.name, asat, x.sat, acnt);
    end
  endtask

  // Monitor: registered outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  localparam logic [3:0] PP_CNT[8] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
  localparam logic       PP_TC[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    bus16.en = 0; bus16.dir = 0; bus16.mode = 0; bus16.load = 0; bus16.load_val = 0;
    bus10.en = 0; bus10.dir = 0; bus10.mode = 0; bus10.load = 0; bus10.load_val = 0;
    bus4.en  = 0; bus4.dir  = 0; bus4.mode  = 0; bus4.load  = 0; bus4.load_val  = 0;
    @(negedge clk);

    // Wrap up, MODULO=16: one tc on the 15 -> 0 step
    applyStimulus(0, 1, 1, 0, 2'b00, 1, 4'd7, 4'd0, 0, 0, "reset16");
    for (int k = 1; k <= 20; k++)
      applyStimulus(0, 0, 1, 0, 2'b00, 0, 4'd0, 4'(k % 16), (k == 16), 0, "wrap16_up");

    // Wrap down, MODULO=10: 0 -> 9 wraps carry tc, load 12 clamps to 9
    applyStimulus(1, 1, 0, 0, 2'b00, 0, 4'd0, 4'd0, 0, 0, "reset10");
    for (int k = 1; k <= 11; k++)
      applyStimulus(1, 0, 1, 1, 2'b00, 0, 4'd0, 4'((10 - (k % 10)) % 10), ((k % 10) == 1), 0,
                    "wrap10_down");
    applyStimulus(1, 0, 1, 1, 2'b00, 1, 4'd12, 4'd9, 0, 0, "load_clamp10");

    // Saturate, MODULO=10
    applyStimulus(1, 1, 0, 0, 2'b01, 0, 4'd0, 4'd0, 0, 0, "reset10_sat");
    for (int k = 1; k <= 12; k++)
      applyStimulus(1, 0, 1, 0, 2'b01, 0, 4'd0, (k < 9) ? 4'(k) : 4'd9, (k == 9), (k >= 10),
                    "sat_up");
    applyStimulus(1, 0, 1, 1, 2'b01, 0, 4'd0, 4'd8, 0, 0, "sat_release");
    applyStimulus(1, 0, 0, 1, 2'b01, 0, 4'd0, 4'd8, 0, 0, "sat_idle");
    applyStimulus(1, 0, 0, 1, 2'b01, 1, 4'd1, 4'd1, 0, 0, "sat_load1");
    applyStimulus(1, 0, 1, 1, 2'b01, 0, 4'd0, 4'd0, 1, 0, "sat_down_arrive");
    applyStimulus(1, 0, 1, 1, 2'b01, 0, 4'd0, 4'd0, 0, 1, "sat_down_block");
    applyStimulus(1, 0, 0, 1, 2'b01, 0, 4'd0, 4'd0, 0, 1, "sat_hold_flag");
    applyStimulus(1, 0, 0, 1, 2'b00, 0, 4'd0, 4'd0, 0, 0, "sat_mode_change");

    // Load priority and reset priority, MODULO=10
    applyStimulus(1, 0, 1, 0, 2'b00, 1, 4'd5, 4'd5, 0, 0, "load_over_step");
    applyStimulus(1, 1, 1, 0, 2'b00, 1, 4'd7, 4'd0, 0, 0, "reset_over_load");
    applyStimulus(1, 0, 0, 0, 2'b01, 1, 4'd9, 4'd9, 0, 0, "load9_sat");
    applyStimulus(1, 0, 1, 0, 2'b01, 0, 4'd0, 4'd9, 0, 1, "sat_at_top");
    applyStimulus(1, 0, 1, 0, 2'b01, 1, 4'd3, 4'd3, 0, 0, "load_clears_sat");

    // Ping-pong, MODULO=4, dir toggling must not matter
    applyStimulus(2, 1, 0, 0, 2'b10, 0, 4'd0, 4'd0, 0, 0, "reset4");
    for (int k = 0; k < 8; k++)
      applyStimulus(2, 0, 1, k[0], 2'b10, 0, 4'd0, PP_CNT[k], PP_TC[k], 0, "pingpong");
    applyStimulus(2, 0, 1, 1, 2'b10, 0, 4'd0, 4'd3, 1, 0, "pp_top");
    applyStimulus(2, 0, 1, 0, 2'b10, 0, 4'd0, 4'd2, 0, 0, "pp_reverse");
    for (int k = 0; k < 3; k++)
      applyStimulus(2, 0, 1, 0, 2'b11, 0, 4'd0, 4'd2, 0, 0, "pp_hold_mode");
    applyStimulus(2, 0, 1, 0, 2'b10, 0, 4'd0, 4'd1, 0, 0, "pp_dir_kept");
    applyStimulus(2, 0, 0, 0, 2'b10, 0, 4'd0, 4'd1, 0, 0, "pp_en_off1");
    applyStimulus(2, 0, 1, 0, 2'b10, 0, 4'd0, 4'd0, 1, 0, "pp_en_on1");
    applyStimulus(2, 0, 0, 0, 2'b10, 0, 4'd0, 4'd0, 0, 0, "pp_en_off2");
    applyStimulus(2, 0, 1, 0, 2'b10, 0, 4'd0, 4'd1, 0, 0, "pp_en_on2");
    applyStimulus(2, 0, 1, 0, 2'b10, 1, 4'd6, 4'd3, 0, 0, "load_clamp4");
    applyStimulus(2, 1, 1, 0, 2'b10, 1, 4'd2, 4'd0, 0, 0, "reset4_over_load");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
